// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite bank of NUM_REGS registers; out-of-range accesses end in SLVERR. `AXIL_SLV_PROT_CHECK_EN adds SLVERR on prot[0]=0.
// Write: AW/W captured independently, commit one edge after both are held. Read: data one edge after AR. Responses hold until accepted.
module axi_lite_reg_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int               STRB_W     = DATA_WIDTH / 8;
    localparam int               IDX_LSB    = $clog2(STRB_W);
    localparam int               IDX_W      = ADDR_WIDTH - IDX_LSB;
    localparam logic [IDX_W-1:0] NREGS_IDX  = IDX_W'(NUM_REGS);
    localparam logic [1:0]       RESP_OKAY  = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e                         w_state_q, w_state_d;
    r_state_e                         r_state_q, r_state_d;
    logic                             aw_full_q, aw_full_d;
    logic [IDX_W-1:0]                 aw_idx_q, aw_idx_d;
    logic                             aw_priv_q, aw_priv_d;
    logic                             w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]            w_data_q, w_data_d;
    logic [STRB_W-1:0]                w_strb_q, w_strb_d;
    logic                             awready_q, awready_d;
    logic                             wready_q, wready_d;
    logic                             bvalid_q, bvalid_d;
    logic [1:0]                       bresp_q, bresp_d;
    logic [NUM_REGS*DATA_WIDTH-1:0]   regs_q, regs_d;
    logic [NUM_REGS-1:0]              wr_pulse_q, wr_pulse_d;
    logic                             arready_q, arready_d;
    logic                             rvalid_q, rvalid_d;
    logic [1:0]                       rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]            rdata_q, rdata_d;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic                  w_ok, r_ok;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic                  unused_bits;

    assign aw_hs  = awvalid & awready_q;
    assign w_hs   = wvalid & wready_q;
    assign b_hs   = bvalid_q & bready;
    assign ar_hs  = arvalid & arready_q;
    assign r_hs   = rvalid_q & rready;
    assign commit = (w_state_q == W_IDLE) & aw_full_q & w_full_q;
    assign ar_idx = araddr[ADDR_WIDTH-1:IDX_LSB];

`ifdef AXIL_SLV_PROT_CHECK_EN
    assign w_ok = (aw_idx_q < NREGS_IDX) & aw_priv_q;
    assign r_ok = (ar_idx < NREGS_IDX) & arprot[0];
`else
    assign w_ok = (aw_idx_q < NREGS_IDX);
    assign r_ok = (ar_idx < NREGS_IDX);
`endif

    assign unused_bits = ^{awprot, arprot, aw_priv_q, awaddr[IDX_LSB-1:0], araddr[IDX_LSB-1:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            aw_priv_q  <= 1'b0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            regs_q     <= {NUM_REGS{RESET_VAL}};
            wr_pulse_q <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            aw_priv_q  <= aw_priv_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (commit) w_state_d = W_RESP;
            W_RESP:  if (b_hs)   w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Readies are computed from next state so they are registered yet still drop the edge a holder fills.
    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        aw_priv_d  = aw_priv_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = awaddr[ADDR_WIDTH-1:IDX_LSB];
            aw_priv_d = awprot[0];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bresp_d   = w_ok ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_ok && (aw_idx_q == IDX_W'(i))) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_strb_q[k]) regs_d[i*DATA_WIDTH + k*8 +: 8] = w_data_q[k*8 +: 8];
                    end
                end
            end
        end
        bvalid_d  = (w_state_d == W_RESP);
        awready_d = (w_state_d == W_IDLE) & ~aw_full_d;
        wready_d  = (w_state_d == W_IDLE) & ~w_full_d;
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) rd_sel = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            rdata_d = r_ok ? rd_sel : '0;
            rresp_d = r_ok ? RESP_OKAY : RESP_SLVERR;
        end
        rvalid_d  = (r_state_d == R_DATA);
        arready_d = (r_state_d == R_IDLE);
    end

    assign awready  = awready_q;
    assign wready   = wready_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign arready  = arready_q;
    assign rvalid   = rvalid_q;
    assign rresp    = rresp_q;
    assign rdata    = rdata_q;
    assign reg_q    = regs_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: vector table, corner-case sequences and random traffic against a register-array model.
module tb_axi_lite_reg_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
`ifdef AXIL_SLV_PROT_CHECK_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    wr_pulse;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] mregs [NR];

    always #5 aclk = ~aclk;

    axi_lite_reg_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RESET_VAL({DW{1'b0}})
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] mflat();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = mregs[i];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input logic [2:0] prot, output logic [1:0] resp, output logic [NR-1:0] pmask);
        int idx;
        bit ok;
        idx   = int'(addr / 4);
        ok    = (idx < NR) && (!PROT || prot[0]);
        pmask = '0;
        resp  = ok ? 2'b00 : 2'b10;
        if (ok) begin
            for (int k = 0; k < 4; k++) if (strb[k]) mregs[idx][k*8 +: 8] = data[k*8 +: 8];
            pmask[idx] = 1'b1;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, input logic [2:0] prot,
                              output logic [31:0] data, output logic [1:0] resp);
        int idx;
        idx  = int'(addr / 4);
        data = '0;
        resp = 2'b10;
        if (idx < NR && (!PROT || prot[0])) begin
            data = mregs[idx];
            resp = 2'b00;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int aw_dly, input int w_dly, input int hold,
                            output logic [1:0] resp, output logic [NR-1:0] pulse_or, output int pulse_cnt);
        bit aw_done, w_done, got, seen, aw_hs, w_hs, b_hs;
        int held;
        logic [1:0] b_first;
        aw_done = 0; w_done = 0; got = 0; seen = 0; held = 0; b_first = '0;
        resp = 2'b11; pulse_or = '0; pulse_cnt = 0;
        awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
        for (int c = 0; c < 40 && !got; c++) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            if (bvalid && !seen) begin
                seen = 1;
                b_first = bresp;
            end
            if (seen && held < hold) begin
                chk("bvalid_hold", bvalid, 1'b1);
                chk("bresp_hold", bresp, b_first);
                chk("wr_ready_in_resp", {awready, wready}, 2'b00);
                held++;
            end
            bready = seen && (held >= hold);
            if (wr_pulse != '0) begin
                pulse_or |= wr_pulse;
                pulse_cnt++;
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            if (b_hs) resp = bresp;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            if (b_hs)  got = 1;
        end
        awvalid = 0; wvalid = 0; bready = 0;
        chk("write_timeout", got, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int dly, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        bit ar_done, got, seen, ar_hs, r_hs;
        int held;
        logic [33:0] r_first;
        ar_done = 0; got = 0; seen = 0; held = 0; r_first = '0;
        data = '1; resp = 2'b11;
        araddr = addr; arprot = prot;
        for (int c = 0; c < 40 && !got; c++) begin
            arvalid = !ar_done && (c >= dly);
            if (rvalid && !seen) begin
                seen = 1;
                r_first = {rresp, rdata};
            end
            if (seen && held < hold) begin
                chk("rvalid_hold", rvalid, 1'b1);
                chk("rdata_hold", {rresp, rdata}, r_first);
                chk("arready_in_data", arready, 1'b0);
                held++;
            end
            rready = seen && (held >= hold);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (r_hs) begin
                data = rdata;
                resp = rresp;
            end
            tick();
            if (ar_hs) ar_done = 1;
            if (r_hs)  got = 1;
        end
        arvalid = 0; rready = 0;
        chk("read_timeout", got, 1'b1);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, input int awd, input int wd, input int hold,
                             output logic [1:0] dresp, output logic [1:0] mresp);
        logic [NR-1:0] dpm, mpm;
        int pc;
        do_write(addr, data, strb, prot, awd, wd, hold, dresp, dpm, pc);
        model_write(addr, data, strb, prot, mresp, mpm);
        chk("wr_reg_q", reg_q, mflat());
        chk("wr_pulse_mask", dpm, mpm);
        chk("wr_pulse_cycles", pc, (mpm != '0) ? 1 : 0);
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [2:0] prot, input int dly, input int hold,
                            output logic [31:0] ddata, output logic [1:0] dresp,
                            output logic [31:0] mdata, output logic [1:0] mresp);
        do_read(addr, prot, dly, hold, ddata, dresp);
        model_read(addr, prot, mdata, mresp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [15];
        logic [1:0]  dr, mr;
        logic [31:0] dd, md, old;
        logic [NR-1:0] pm;

        tbl[0]  = '{1, 32'h00, 32'h0,        4'h0, 3'b001, 0, 0, 2'b00, 32'h0};
        tbl[0]  = '{1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 2'b00, 32'h0};
        tbl[1]  = '{0, 32'h04, 32'h0,        4'h0, 3'b001, 0, 0, 2'b00, 32'hDEADBEEF};
        tbl[2]  = '{1, 32'h08, 32'h11223344, 4'h5, 3'b001, 3, 0, 2'b00, 32'h0};
        tbl[3]  = '{0, 32'h08, 32'h0,        4'h0, 3'b001, 0, 0, 2'b00, 32'h00220044};
        tbl[4]  = '{1, 32'h40, 32'h12345678, 4'hF, 3'b001, 0, 0, 2'b10, 32'h0};
        tbl[5]  = '{0, 32'h40, 32'h0,        4'h0, 3'b001, 0, 0, 2'b10, 32'h0};
        tbl[6]  = '{1, 32'h00, 32'h0000005A, 4'hF, 3'b000, 0, 0, PROT ? 2'b10 : 2'b00, 32'h0};
        tbl[7]  = '{0, 32'h00, 32'h0,        4'h0, 3'b001, 0, 0, 2'b00, PROT ? 32'h0 : 32'h5A};
        tbl[8]  = '{1, 32'h00, 32'h0000005A, 4'hF, 3'b001, 0, 2, 2'b00, 32'h0};
        tbl[9]  = '{0, 32'h00, 32'h0,        4'h0, 3'b000, 0, 0, PROT ? 2'b10 : 2'b00, PROT ? 32'h0 : 32'h5A};
        tbl[10] = '{1, 32'h05, 32'hFFFFFFFF, 4'h0, 3'b001, 0, 0, 2'b00, 32'h0};
        tbl[11] = '{0, 32'h07, 32'h0,        4'h0, 3'b001, 0, 0, 2'b00, 32'hDEADBEEF};
        tbl[12] = '{1, 32'h3C, 32'hA0B0C0D0, 4'h8, 3'b001, 1, 1, 2'b00, 32'h0};
        tbl[13] = '{0, 32'h3C, 32'h0,        4'h0, 3'b001, 0, 0, 2'b00, 32'hA0000000};
        tbl[14] = '{0, 32'h43, 32'h0,        4'h0, 3'b001, 0, 0, 2'b10, 32'h0};

        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arprot = '0; arvalid = 0; rready = 0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;

        repeat (3) tick();
        chk("rst_handshake", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        chk("rst_resp", {bresp, rresp}, 4'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_reg_q", reg_q, mflat());
        chk("rst_wr_pulse", wr_pulse, 16'h0);
        aresetn = 1'b1;
        tick();
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);
        chk("post_rst_valid", {bvalid, rvalid}, 2'b00);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) begin
                run_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].prot,
                          tbl[i].aw_dly, tbl[i].w_dly, 0, dr, mr);
                chk($sformatf("vec%0d_bresp", i), dr, tbl[i].exp_resp);
            end else begin
                run_read(tbl[i].addr, tbl[i].prot, 0, 0, dd, dr, md, mr);
                chk($sformatf("vec%0d_rresp", i), dr, tbl[i].exp_resp);
                chk($sformatf("vec%0d_rdata", i), dd, tbl[i].exp_rdata);
            end
        end

        // Response back-pressure: bready/rready held low for 5 cycles.
        run_write(32'h0C, 32'hA5A50F0F, 4'hF, 3'b001, 0, 0, 5, dr, mr);
        chk("hold_bresp", dr, 2'b00);
        chk("hold_ready_back", {awready, wready}, 2'b11);
        run_read(32'h0C, 3'b001, 0, 5, dd, dr, md, mr);
        chk("hold_rdata", dd, 32'hA5A50F0F);
        chk("hold_rresp", dr, 2'b00);
        chk("hold_arready_back", arready, 1'b1);

        // Read sampled on the same edge as a write commit to that register sees the old value.
        old = mregs[5];
        awaddr = 32'h14; awprot = 3'b001; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        chk("same_edge_ready", {awready, wready, arready}, 3'b111);
        tick();
        awvalid = 0; wvalid = 0;
        chk("same_edge_bvalid_early", bvalid, 1'b0);
        chk("same_edge_holders_full", {awready, wready}, 2'b00);
        araddr = 32'h14; arprot = 3'b001; arvalid = 1;
        tick();
        arvalid = 0;
        chk("same_edge_bvalid", {bvalid, bresp}, 3'b100);
        chk("same_edge_rvalid", {rvalid, rresp}, 3'b100);
        chk("same_edge_old_data", rdata, old);
        chk("same_edge_pulse", wr_pulse, 16'h0020);
        model_write(32'h14, 32'hCAFEF00D, 4'hF, 3'b001, mr, pm);
        chk("same_edge_reg_q", reg_q, mflat());
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        chk("same_edge_done", {bvalid, rvalid, awready, wready, arready}, 5'b00111);

        // Reset while a write is held but not yet committed: it is dropped without a response.
        awaddr = 32'h18; awprot = 3'b001; wdata = 32'h00000077; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        aresetn = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        chk("midrst_handshake", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        chk("midrst_reg_q", reg_q, mflat());
        chk("midrst_rdata", {rdata, rresp, bresp}, 36'h0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("midrst_ready", {awready, wready, arready}, 3'b111);
        repeat (2) begin
            tick();
            chk("midrst_no_resp", {bvalid, wr_pulse}, 17'h0);
            chk("midrst_reg_q_after", reg_q, mflat());
        end

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            logic [2:0]  p;
            a = 32'($urandom_range(0, (NR + 3) * 4 - 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                run_write(a, d, s, p, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), dr, mr);
                chk("rnd_bresp", dr, mr);
            end else begin
                run_read(a, p, $urandom_range(0, 2), $urandom_range(0, 2), dd, dr, md, mr);
                chk("rnd_rresp", dr, mr);
                chk("rnd_rdata", dd, md);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
